// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte-stream input and instruction-memory/status outputs of the boot loader
interface instr_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_loaded_o;

    // Loader side
    modport slave (
        input  byte_valid_i, byte_data_i,
        output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
               cpu_rst_o, done_o, err_o, words_loaded_o
    );

    // Stream source / system side
    modport master (
        output byte_valid_i, byte_data_i,
        input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
               cpu_rst_o, done_o, err_o, words_loaded_o
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader: framed bytes to instruction words, checksum gate on CPU reset
module instr_loader #(
    parameter int          MAX_WORDS = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_loader_if.slave  bus
);
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [15:0] r_len;
    logic [7:0]  r_sum;
    logic [23:0] r_asm;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [15:0] r_words;

    logic        w_ready;
    logic        w_accept;
    logic        w_cpu_rst;
    logic        w_done;
    logic        w_err;
    logic        w_word_done;
    logic        w_len_bad;
    logic [15:0] w_len_full;
    logic [7:0]  w_sum_next;
    logic [31:0] w_word;

    assign w_len_full = {bus.byte_data_i, r_len[7:0]};
    assign w_len_bad  = (w_len_full == 16'd0) || ({1'b0, w_len_full} > MAX_W);
    assign w_sum_next = r_sum + bus.byte_data_i;
    assign w_word     = {r_asm, bus.byte_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_cpu_rst    = 1'b1;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_accept     = 1'b0;
        w_word_done  = 1'b0;

        case (r_state)
            S_LEN, S_DATA, S_CSUM: w_ready = 1'b1;
            S_DONE: begin
                w_cpu_rst = 1'b0;
                w_done    = 1'b1;
            end
            S_ERR:   w_err = 1'b1;
            default: w_err = 1'b0;
        endcase

        w_accept    = bus.byte_valid_i & w_ready;
        w_word_done = w_accept && (r_state == S_DATA) && (r_cnt == 2'd3);

        case (r_state)
            S_LEN: begin
                if (w_accept && r_cnt == 2'd1) begin
                    w_state_next = w_len_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                // Last word of the image: checksum byte comes next
                if (w_word_done && (r_words + 16'd1 == r_len)) begin
                    w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_next = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= 2'd0;
            r_len   <= 16'd0;
            r_sum   <= 8'd0;
            r_asm   <= 24'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_words <= 16'd0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                r_sum <= w_sum_next;
            end
            if (w_accept && r_state == S_LEN) begin
                if (r_cnt == 2'd0) begin
                    r_len[7:0] <= bus.byte_data_i;
                    r_cnt      <= 2'd1;
                end else begin
                    r_len[15:8] <= bus.byte_data_i;
                    r_cnt       <= 2'd0;
                end
            end
            if (w_accept && r_state == S_DATA) begin
                r_asm <= w_word[23:0];
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_word_done) begin
                r_we    <= 1'b1;
                r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
                r_data  <= w_word;
                r_words <= r_words + 16'd1;
            end
        end
    end

    assign bus.byte_ready_o   = w_ready;
    assign bus.imem_we_o      = r_we;
    assign bus.imem_addr_o    = r_addr;
    assign bus.imem_data_o    = r_data;
    assign bus.cpu_rst_o      = w_cpu_rst;
    assign bus.done_o         = w_done;
    assign bus.err_o          = w_err;
    assign bus.words_loaded_o = r_words;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized frame stimulus against a frame-level reference model
module tb_instr_loader;
    localparam int          MAXW = 128;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_loader_if bus ();

    instr_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  tx[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    int          exp_consumed;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;

    always @(negedge clk) begin
        if (bus.imem_we_o === 1'b1) begin
            got_a.push_back(bus.imem_addr_o);
            got_d.push_back(bus.imem_data_o);
        end
    end

    // Frame-level expectation for whatever prefix of tx reaches the loader
    task automatic model();
        int n;
        int len;
        int s;
        exp_a.delete();
        exp_d.delete();
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_words    = 0;
        exp_consumed = 1 << 30;
        n = tx.size();
        if (n < 2) return;
        len = int'(tx[0]) + 256 * int'(tx[1]);
        if (len == 0 || len > MAXW) begin
            exp_err      = 1'b1;
            exp_consumed = 2;
            return;
        end
        exp_consumed = 3 + 4 * len;
        for (int k = 0; k < len; k++) begin
            if (5 + 4 * k < n) begin
                exp_a.push_back(BASE + 32'(4 * k));
                exp_d.push_back({tx[2+4*k], tx[3+4*k], tx[4+4*k], tx[5+4*k]});
                exp_words++;
            end
        end
        if (n >= exp_consumed) begin
            s = 0;
            for (int i = 0; i < exp_consumed; i++) s += int'(tx[i]);
            if (s % 256 == 0) exp_done = 1'b1;
            else              exp_err  = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        check("rst.ready", 32'(bus.byte_ready_o), 32'd1);
        check("rst.cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        check("rst.we", 32'(bus.imem_we_o), 32'd0);
        check("rst.addr", bus.imem_addr_o, 32'd0);
        check("rst.data", bus.imem_data_o, 32'd0);
        check("rst.done", 32'(bus.done_o), 32'd0);
        check("rst.err", 32'(bus.err_o), 32'd0);
        check("rst.words", 32'(bus.words_loaded_o), 32'd0);
        got_a.delete();
        got_d.delete();
    endtask

    task automatic send_frame(input int maxgap, input string nm);
        int acc = 0;
        bit took;
        model();
        foreach (tx[i]) begin
            repeat ($urandom_range(0, maxgap)) begin
                bus.byte_valid_i = 1'b0;
                bus.byte_data_i  = 8'($urandom);
                @(negedge clk);
            end
            bus.byte_valid_i = 1'b1;
            bus.byte_data_i  = tx[i];
            took = (acc < exp_consumed);
            check({nm, ".ready"}, 32'(bus.byte_ready_o), 32'(took));
            if (took) acc++;
            @(negedge clk);
            if (took && acc == exp_consumed) begin
                check({nm, ".end_done"}, 32'(bus.done_o), 32'(exp_done));
                check({nm, ".end_err"}, 32'(bus.err_o), 32'(exp_err));
                check({nm, ".end_cpu_rst"}, 32'(bus.cpu_rst_o), 32'(!exp_done));
                check({nm, ".end_ready"}, 32'(bus.byte_ready_o), 32'd0);
            end
        end
        bus.byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check({nm, ".nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check($sformatf("%s.addr%0d", nm, i), got_a[i], exp_a[i]);
            check($sformatf("%s.data%0d", nm, i), got_d[i], exp_d[i]);
        end
        check({nm, ".words"}, 32'(bus.words_loaded_o), 32'(exp_words));
        check({nm, ".done"}, 32'(bus.done_o), 32'(exp_done));
        check({nm, ".err"}, 32'(bus.err_o), 32'(exp_err));
        check({nm, ".cpu_rst"}, 32'(bus.cpu_rst_o), 32'(!exp_done));
        check({nm, ".ready_final"}, 32'(bus.byte_ready_o), 32'(acc < exp_consumed));
        check({nm, ".exclusive"}, 32'(bus.done_o & bus.err_o), 32'd0);
    endtask

    task automatic load_good();
        logic [7:0] good [11] = '{8'h02, 8'h00, 8'h20, 8'h01, 8'h00, 8'h05,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'hD8};
        tx.delete();
        foreach (good[i]) tx.push_back(good[i]);
    endtask

    task automatic build_random(input int len, input bit bad);
        int s;
        tx.delete();
        tx.push_back(8'(len));
        tx.push_back(8'(len >> 8));
        s = int'(tx[0]) + int'(tx[1]);
        for (int i = 0; i < 4 * len; i++) begin
            tx.push_back(8'($urandom));
            s += int'(tx[tx.size()-1]);
        end
        tx.push_back(8'(256 - (s % 256) + (bad ? 1 : 0)));
    endtask

    initial begin
        logic [7:0] keep[$];

        do_reset();
        load_good();
        send_frame(0, "good");

        do_reset();
        load_good();
        tx[10] = 8'hD9;
        send_frame(0, "badsum");

        do_reset();
        tx = {8'h00, 8'h00, 8'h12, 8'h34};
        send_frame(0, "len0");

        do_reset();
        tx = {8'h81, 8'h00, 8'h12, 8'h34};
        send_frame(0, "len129");

        do_reset();
        tx = {8'h00, 8'h01, 8'h12, 8'h34};
        send_frame(1, "len256");

        do_reset();
        load_good();
        send_frame(5, "gapped");

        do_reset();
        load_good();
        for (int i = 0; i < 10; i++) tx.push_back(8'($urandom));
        send_frame(2, "postdone");

        // Reset arrives after the 2nd byte of word 1
        do_reset();
        load_good();
        keep = tx;
        tx = keep[0:7];
        send_frame(0, "partial");
        do_reset();
        load_good();
        send_frame(0, "reload");

        // Reset coincides with the byte that would complete word 0
        do_reset();
        load_good();
        keep = tx;
        tx = keep[0:4];
        send_frame(0, "pre4th");
        rst              = 1'b1;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = keep[5];
        @(negedge clk);
        check("rst4.we", 32'(bus.imem_we_o), 32'd0);
        check("rst4.words", 32'(bus.words_loaded_o), 32'd0);
        check("rst4.ready", 32'(bus.byte_ready_o), 32'd1);
        do_reset();
        load_good();
        send_frame(0, "after_rst4");

        do_reset();
        build_random(MAXW, 1'b0);
        send_frame(0, "maxlen");

        for (int r = 0; r < 6; r++) begin
            do_reset();
            build_random(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            send_frame(3, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
